// File: rtl/keypad_pkg.sv
// ============================================================================
// keypad_pkg : state type, key-value map and encoder shared by the keypad scanner
// Revision   : 1.0
// ============================================================================
`default_nettype none

package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN      = 2'd0,
      DEB_PRESS = 2'd1,
      EMIT      = 2'd2,
      HELD      = 2'd3
   } kp_state_t;

   // Index is row*4+col; entry 15 is the close key and never reaches o_code.
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   function automatic logic [1:0] onehot4_to_bin(input logic [3:0] oh);
      logic [1:0] bin;
      bin = 2'd0;
      case (oh)
         4'b0010: bin = 2'd1;
         4'b0100: bin = 2'd2;
         4'b1000: bin = 2'd3;
         default: bin = 2'd0;
      endcase
      return bin;
   endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_code_tx_scan_tick_gen.sv
// ============================================================================
// scan_tick_gen : free-running divider, one-cycle tick every SCAN_DIV clocks
// Revision      : 1.0
// ============================================================================
`default_nettype none

module scan_tick_gen #(
   parameter int SCAN_DIV = 100000
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tick
);

   localparam int               CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0]    CNT_MAX = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_tick = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/keypad_code_tx.sv
// ============================================================================
// keypad_code_tx : 4x4 keypad scanner with debounce, emits one code/close strobe per press
// Revision       : 1.0
// ============================================================================
`default_nettype none

module keypad_code_tx
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int DEBOUNCE  = 4,
   parameter int CLOSE_KEY = 15
) (
   input  logic       i_clk,
   input  logic       i_rst,
   output logic [3:0] o_col,
   input  logic [3:0] i_row,
   output logic [3:0] o_code,
   output logic       o_code_vld,
   output logic       o_close
);

   localparam int            DW      = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
   localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE);

   logic       tick;

   logic [3:0] row_meta_q;
   logic [3:0] row_s_q;

   kp_state_t     state_q,    state_d;
   logic [3:0]    col_q,      col_d;
   logic [3:0]    col_l_q,    col_l_d;
   logic [3:0]    row_l_q,    row_l_d;
   logic [DW-1:0] dcnt_q,     dcnt_d;
   logic [3:0]    code_q,     code_d;
   logic          code_vld_q, code_vld_d;
   logic          close_q,    close_d;

   logic [3:0]    col_rot;
   logic          row_onehot;
   logic [3:0]    idx;
   logic          is_close;
   logic [DW-1:0] dcnt_inc;

   scan_tick_gen #(
      .SCAN_DIV (SCAN_DIV)
   ) u_tick (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .o_tick (tick)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         row_meta_q <= '0;
         row_s_q    <= '0;
      end else begin
         row_meta_q <= i_row;
         row_s_q    <= row_meta_q;
      end
   end

   assign col_rot    = {col_q[2:0], col_q[3]};
   assign row_onehot = (row_s_q != 4'd0) && ((row_s_q & (row_s_q - 4'd1)) == 4'd0);
   assign idx        = {onehot4_to_bin(row_l_q), onehot4_to_bin(col_l_q)};
   assign is_close   = (idx == 4'(CLOSE_KEY));
   assign dcnt_inc   = (dcnt_q == DEB_MAX) ? dcnt_q : dcnt_q + DW'(1);

   // Output strobes are loaded on the DEB_PRESS->EMIT edge so they are high
   // exactly during the EMIT cycle, with o_code already valid alongside.
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      col_l_d    = col_l_q;
      row_l_d    = row_l_q;
      dcnt_d     = dcnt_q;
      code_d     = code_q;
      code_vld_d = 1'b0;
      close_d    = 1'b0;

      case (state_q)
         SCAN: begin
            if (tick) begin
               if (row_onehot) begin
                  col_l_d = col_q;
                  row_l_d = row_s_q;
                  dcnt_d  = '0;
                  state_d = DEB_PRESS;
               end else begin
                  col_d = col_rot;
               end
            end
         end

         DEB_PRESS: begin
            if (tick) begin
               if (row_s_q == row_l_q) begin
                  dcnt_d = dcnt_inc;
                  if (dcnt_inc == DEB_MAX) begin
                     state_d = EMIT;
                     if (is_close) begin
                        close_d = 1'b1;
                     end else begin
                        code_d     = KEY_MAP[idx];
                        code_vld_d = 1'b1;
                     end
                  end
               end else begin
                  state_d = SCAN;
                  col_d   = col_rot;
               end
            end
         end

         EMIT: begin
            dcnt_d  = '0;
            state_d = HELD;
         end

         HELD: begin
            // Any row activity restarts the release count, so rolling onto
            // another key while held can never produce a second strobe.
            if (tick) begin
               if (row_s_q == 4'd0) begin
                  dcnt_d = dcnt_inc;
                  if (dcnt_inc == DEB_MAX) begin
                     state_d = SCAN;
                     col_d   = col_rot;
                  end
               end else begin
                  dcnt_d = '0;
               end
            end
         end

         default: begin
            state_d = SCAN;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= SCAN;
         col_q      <= 4'b0001;
         col_l_q    <= '0;
         row_l_q    <= '0;
         dcnt_q     <= '0;
         code_q     <= '0;
         code_vld_q <= 1'b0;
         close_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         col_l_q    <= col_l_d;
         row_l_q    <= row_l_d;
         dcnt_q     <= dcnt_d;
         code_q     <= code_d;
         code_vld_q <= code_vld_d;
         close_q    <= close_d;
      end
   end

   assign o_col      = col_q;
   assign o_code     = code_q;
   assign o_code_vld = code_vld_q;
   assign o_close    = close_q;

endmodule

`default_nettype wire
